// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the binary<->decimal conversion paths.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX    = 4'd9;
    localparam bcd_digit_t ADJ_THRESH = 4'd8;
    localparam bcd_digit_t ADJ_VAL    = 4'd3;

endpackage

// File: rtl/bcd_nib_adj.sv
// One BCD digit correction step of reverse double-dabble: digits >= 8 lose 3.
module bcd_nib_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adjusted
);

    assign adjusted = (digit >= ADJ_THRESH) ? bcd_digit_t'(digit - ADJ_VAL) : digit;

endmodule

// File: rtl/bcd_to_bin_serial.sv
// Serial packed-BCD to binary converter, one shift per clock (reverse double-dabble).
// Define BCD_CHECK_EN to flag digits above 9 instead of converting them.
module bcd_to_bin_serial
    import bcd_pkg::*;
#(
    parameter int NDIG  = 2,
    parameter int BIN_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4*NDIG-1:0] bcd_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [BIN_W-1:0]  bin_o,
    output logic              err_o,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int BCD_W = 4 * NDIG;
    localparam int SR_W  = 8 * NDIG;
    localparam int CNT_W = $clog2(4 * NDIG + 1);

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   shifted;
    logic [BCD_W-1:0]  adj_bcd;
    logic [SR_W-1:0]   next_sr;

    assign shifted = sr >> 1;

    genvar k;
    generate
        for (k = 0; k < NDIG; k++) begin : g_adj
            bcd_nib_adj u_adj (
                .digit    (shifted[BCD_W + 4*k +: 4]),
                .adjusted (adj_bcd[4*k +: 4])
            );
        end
    endgenerate

    assign next_sr = {adj_bcd, shifted[BCD_W-1:0]};

`ifdef BCD_CHECK_EN
    logic bad_digit;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_i[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
        end
    end
`endif

    // The counter runs one past the last shift so the result register loads on its own edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            bin_o     <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
`ifdef BCD_CHECK_EN
                        if (bad_digit) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            bin_o     <= '0;
                            err_o     <= 1'b1;
                        end else begin
                            sr    <= {bcd_i, {BCD_W{1'b0}}};
                            cnt   <= '0;
                            state <= CONV;
                        end
`else
                        sr    <= {bcd_i, {BCD_W{1'b0}}};
                        cnt   <= '0;
                        state <= CONV;
`endif
                    end
                end
                CONV: begin
                    if (cnt == CNT_W'(4 * NDIG)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        bin_o     <= BIN_W'(sr[BCD_W-1:0]);
                        err_o     <= 1'b0;
                    end else begin
                        sr  <= next_sr;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_serial.sv
// Scoreboard bench for bcd_to_bin_serial; expected values come from decimal arithmetic on the digits.
module tb_bcd_to_bin_serial;

    localparam int NDIG  = 2;
    localparam int BIN_W = 7;
    localparam int LAT   = 4 * NDIG + 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [4*NDIG-1:0] bcd_i = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [BIN_W-1:0]  bin_o;
    logic              err_o;
    logic              out_valid;
    logic              out_ready = 1'b0;

    bcd_to_bin_serial #(.NDIG(NDIG), .BIN_W(BIN_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bcd_i     (bcd_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_o     (bin_o),
        .err_o     (err_o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [BIN_W-1:0] bin;
        logic             err;
        bit               check_bin;
        int               accept;
        int               lat;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               cyc = 0;
    int               checks = 0;
    int               fails = 0;
    bit               seen = 0;
    logic [BIN_W-1:0] held_bin;
    logic             held_err;
    int               hold_cycles = 0;
    bit               rand_ready = 0;
    int               last_pop = 0;
    int               last_accept = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference: value = sum of digits weighted by powers of ten.
    function automatic exp_t model(input logic [4*NDIG-1:0] v, input int acc);
        exp_t e;
        int   val = 0;
        bit   bad = 0;
        for (int d = NDIG - 1; d >= 0; d--) begin
            int dig;
            dig = int'(v[4*d +: 4]);
            if (dig > 9) bad = 1;
            val = val * 10 + dig;
        end
        e.bin       = BIN_W'(val);
        e.err       = 1'b0;
        e.check_bin = 1;
        e.accept    = acc;
        e.lat       = LAT;
`ifdef BCD_CHECK_EN
        if (bad) begin
            e.bin = '0;
            e.err = 1'b1;
            e.lat = 1;
        end
`else
        if (bad) e.check_bin = 0;
`endif
        return e;
    endfunction

    task automatic applyStimulus(input logic [4*NDIG-1:0] v);
        int w = 0;
        @(negedge clk);
        bcd_i    = v;
        in_valid = 1'b1;
        while (!in_ready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        last_accept = cyc + 1;
        sb.push_back(model(v, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        bcd_i    = 4*NDIG'($urandom);
    endtask

    task automatic waitDrain();
        int w = 0;
        while (sb.size() > 0 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() > 0) checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: checks a result the first time it appears, then its stability until popped.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen      = 0;
            out_ready = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious_out_valid", 1, 0);
                end else begin
                    mon_e = sb[0];
                    if (mon_e.check_bin) checkOutput("bin_o", 32'(bin_o), 32'(mon_e.bin));
                    checkOutput("err_o", 32'(err_o), 32'(mon_e.err));
                    checkOutput("latency", cyc - mon_e.accept, mon_e.lat);
                end
                seen     = 1;
                held_bin = bin_o;
                held_err = err_o;
            end else begin
                checkOutput("bin_hold", 32'(bin_o), 32'(held_bin));
                checkOutput("err_hold", 32'(err_o), 32'(held_err));
            end
            checkOutput("in_ready_in_done", 32'(in_ready), 0);
            if (hold_cycles > 0) begin
                out_ready = 1'b0;
                hold_cycles--;
            end else begin
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_ready) begin
                seen     = 0;
                last_pop = cyc + 1;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end else begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, %0d pending", sb.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #23;
        checkOutput("reset_in_ready", 32'(in_ready), 1);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_bin_o", 32'(bin_o), 0);
        checkOutput("reset_err_o", 32'(err_o), 0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(8'h29);
        waitDrain();
        applyStimulus(8'h99);
        waitDrain();
        applyStimulus(8'h00);
        waitDrain();

        hold_cycles = 5;
        applyStimulus(8'h15);
        applyStimulus(8'h30);
        checkOutput("reaccept_gap", last_accept - last_pop, 1);
        waitDrain();

        applyStimulus(8'h47);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midconv_reset_out_valid", 32'(out_valid), 0);
        checkOutput("midconv_reset_in_ready", 32'(in_ready), 1);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(8'h12);
        waitDrain();

        applyStimulus(8'h1A);
        waitDrain();

        rand_ready = 1;
        for (int i = 0; i < 40; i++) begin
            logic [3:0] tens;
            logic [3:0] units;
            tens  = 4'($urandom_range(0, 9));
            units = 4'($urandom_range(0, 9));
            applyStimulus({tens, units});
            if ($urandom_range(0, 3) == 0) waitDrain();
        end
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
